// File: rtl/mdsa_input_loader.sv
// Buffers one ROWS x COLS matrix from a valid/ready stream and replays it to MDSA_top as start pulse + en burst.
// Optional two-bank ping-pong buffering is enabled with `define MDSA_LOADER_PINGPONG_EN.
module mdsa_input_loader #(
  parameter int DATA_W       = 8,
  parameter int ROWS         = 3,
  parameter int COLS         = 3,
  parameter int START_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              start,
  output logic              en,
  output logic [DATA_W-1:0] data_in,
  input  logic              rdy,
  output logic              frame_err,
  output logic              busy,
  output logic [15:0]       mat_cnt
);

  localparam int N  = ROWS * COLS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

`ifdef MDSA_LOADER_PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif

  typedef enum logic [2:0] {ST_IDLE, ST_FILL, ST_LAUNCH, ST_STREAM, ST_WAIT} state_t;

  state_t            state_r;
  logic [IW-1:0]     wr_cnt_r;
  logic [IW-1:0]     rd_cnt_r;
  logic [SW-1:0]     st_cnt_r;
  logic              wr_bank_r;
  logic              rd_bank_r;
  logic [1:0]        full_r;
  logic              s_ready_r;
  logic              start_r;
  logic              en_r;
  logic [DATA_W-1:0] data_in_r;
  logic              frame_err_r;
  logic              busy_r;
  logic [15:0]       mat_cnt_r;
  logic [DATA_W-1:0] mem_r [2][N];

  logic              accept_s;
  logic              at_last_s;
  logic              complete_s;
  logic              early_s;
  logic              release_s;
  logic [1:0]        full_nxt_s;
  logic              wr_bank_nxt_s;
  logic              other_ready_s;
  logic              fill_busy_s;

  assign accept_s      = s_valid & s_ready_r;
  assign at_last_s     = (wr_cnt_r == IW'(N - 1));
  assign complete_s    = accept_s & at_last_s;
  assign early_s       = accept_s & s_last & ~at_last_s;
  assign release_s     = (state_r == ST_WAIT) & rdy;
  // A bank is held from completion until the sorter releases it in WAIT.
  assign full_nxt_s[0] = (full_r[0] & ~(release_s & ~rd_bank_r)) | (complete_s & ~wr_bank_r);
  assign full_nxt_s[1] = (full_r[1] & ~(release_s &  rd_bank_r)) | (complete_s &  wr_bank_r);
  assign wr_bank_nxt_s = complete_s ? (wr_bank_r ^ PP) : wr_bank_r;
  assign other_ready_s = PP & full_nxt_s[~rd_bank_r];
  assign fill_busy_s   = accept_s ? ~(complete_s | early_s) : (wr_cnt_r != {IW{1'b0}});

  assign s_ready   = s_ready_r;
  assign start     = start_r;
  assign en        = en_r;
  assign data_in   = data_in_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;
  assign mat_cnt   = mat_cnt_r;

  // Element storage, written in arrival order into the filling bank.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[wr_bank_r][wr_cnt_r] <= s_data;
    end
  end

  // Fill bookkeeping and launch sequencer with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      wr_cnt_r    <= {IW{1'b0}};
      rd_cnt_r    <= {IW{1'b0}};
      st_cnt_r    <= {SW{1'b0}};
      wr_bank_r   <= 1'b0;
      rd_bank_r   <= 1'b0;
      full_r      <= 2'b00;
      s_ready_r   <= 1'b0;
      start_r     <= 1'b0;
      en_r        <= 1'b0;
      data_in_r   <= {DATA_W{1'b0}};
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
      mat_cnt_r   <= 16'd0;
    end else begin
      frame_err_r <= 1'b0;
      full_r      <= full_nxt_s;
      wr_bank_r   <= wr_bank_nxt_s;
      s_ready_r   <= ~full_nxt_s[wr_bank_nxt_s];
      if (accept_s) begin
        if (at_last_s) begin
          wr_cnt_r    <= {IW{1'b0}};
          frame_err_r <= ~s_last;
        end else if (s_last) begin
          wr_cnt_r    <= {IW{1'b0}};
          frame_err_r <= 1'b1;
        end else begin
          wr_cnt_r    <= wr_cnt_r + IW'(1);
        end
      end
      case (state_r)
        ST_IDLE, ST_FILL: begin
          if (complete_s) begin
            state_r   <= ST_LAUNCH;
            rd_bank_r <= wr_bank_r;
            st_cnt_r  <= {SW{1'b0}};
            start_r   <= 1'b1;
            busy_r    <= 1'b1;
            mat_cnt_r <= mat_cnt_r + 16'd1;
          end else begin
            state_r   <= fill_busy_s ? ST_FILL : ST_IDLE;
            busy_r    <= fill_busy_s;
          end
        end
        ST_LAUNCH: begin
          if (st_cnt_r == SW'(START_CYCLES - 1)) begin
            state_r   <= ST_STREAM;
            start_r   <= 1'b0;
            en_r      <= 1'b1;
            rd_cnt_r  <= {IW{1'b0}};
            data_in_r <= mem_r[rd_bank_r][IW'(0)];
          end else begin
            st_cnt_r  <= st_cnt_r + SW'(1);
          end
        end
        ST_STREAM: begin
          if (rd_cnt_r == IW'(N - 1)) begin
            state_r   <= ST_WAIT;
            en_r      <= 1'b0;
            data_in_r <= {DATA_W{1'b0}};
          end else begin
            rd_cnt_r  <= rd_cnt_r + IW'(1);
            data_in_r <= mem_r[rd_bank_r][rd_cnt_r + IW'(1)];
          end
        end
        ST_WAIT: begin
          if (release_s) begin
            // With the other bank already full, relaunch without passing through IDLE.
            if (other_ready_s) begin
              state_r   <= ST_LAUNCH;
              rd_bank_r <= ~rd_bank_r;
              st_cnt_r  <= {SW{1'b0}};
              start_r   <= 1'b1;
              busy_r    <= 1'b1;
              mat_cnt_r <= mat_cnt_r + 16'd1;
            end else begin
              state_r   <= fill_busy_s ? ST_FILL : ST_IDLE;
              busy_r    <= fill_busy_s;
            end
          end else begin
            busy_r    <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          start_r   <= 1'b0;
          en_r      <= 1'b0;
          data_in_r <= {DATA_W{1'b0}};
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdsa_input_loader.sv
// Directed/randomized bench for mdsa_input_loader; expectations come from the start/en timing rules and queued matrix data.
module tb_mdsa_input_loader;

  localparam int DATA_W = 8;
  localparam int ROWS   = 3;
  localparam int COLS   = 3;
  localparam int SC     = 4;
  localparam int N      = ROWS * COLS;

`ifdef MDSA_LOADER_PINGPONG_EN
  localparam logic [31:0] SRDY_BUSY = 32'd1;
`else
  localparam logic [31:0] SRDY_BUSY = 32'd0;
`endif

  typedef logic [DATA_W-1:0] mat_t [N];

  logic              clk;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              start;
  logic              en;
  logic [DATA_W-1:0] data_in;
  logic              rdy;
  logic              frame_err;
  logic              busy;
  logic [15:0]       mat_cnt;

  int n_vec   = 0;
  int n_err   = 0;
  int exp_mat = 0;

  mdsa_input_loader #(
    .DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS), .START_CYCLES(SC)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .start(start), .en(en), .data_in(data_in), .rdy(rdy),
    .frame_err(frame_err), .busy(busy), .mat_cnt(mat_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic fill_rand(output mat_t m);
    for (int i = 0; i < N; i++) m[i] = DATA_W'($urandom);
  endtask

  // Drives cnt elements; returns at the falling edge after the final accepting edge.
  task automatic send(input mat_t d, input int cnt, input int last_idx, input int max_gap);
    for (int i = 0; i < cnt; i++) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) begin
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
      @(negedge clk);
      chk("s_ready_fill", 32'(s_ready), 32'd1);
      s_valid = 1'b1;
      s_data  = d[i];
      s_last  = (i == last_idx);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Expects SC start cycles then N en cycles carrying d, ending in the first WAIT cycle.
  task automatic check_launch(input mat_t d, input logic fe_want, input logic chk_srdy);
    exp_mat++;
    for (int c = 0; c < SC; c++) begin
      chk("start_hi", 32'(start), 32'd1);
      chk("en_lo_in_start", 32'(en), 32'd0);
      chk("data_zero_in_start", 32'(data_in), 32'd0);
      if (c == 0) begin
        chk("frame_err_at_launch", 32'(frame_err), 32'(fe_want));
        chk("mat_cnt", 32'(mat_cnt), 32'(exp_mat));
      end
      @(negedge clk);
    end
    for (int i = 0; i < N; i++) begin
      chk("en_hi", 32'(en), 32'd1);
      chk("start_lo_in_stream", 32'(start), 32'd0);
      chk("data_in", 32'(data_in), 32'(d[i]));
      if (chk_srdy) chk("s_ready_stream", 32'(s_ready), SRDY_BUSY);
      @(negedge clk);
    end
    chk("en_lo_after", 32'(en), 32'd0);
    chk("data_zero_after", 32'(data_in), 32'd0);
    chk("start_lo_after", 32'(start), 32'd0);
    chk("busy_in_wait", 32'(busy), 32'd1);
  endtask

  task automatic finish_wait(input int hold);
    for (int k = 0; k < hold; k++) begin
      chk("busy_hold", 32'(busy), 32'd1);
      chk("s_ready_hold", 32'(s_ready), SRDY_BUSY);
      @(negedge clk);
    end
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    chk("busy_release", 32'(busy), 32'd0);
    chk("s_ready_release", 32'(s_ready), 32'd1);
  endtask

  initial begin
    mat_t m;
    mat_t m2;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_data_in", 32'(data_in), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mat_cnt", 32'(mat_cnt), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("s_ready_after_rst", 32'(s_ready), 32'd1);

    // Basic launch: 9,8,...,1
    for (int i = 0; i < N; i++) m[i] = DATA_W'(N - i);
    send(m, N, N - 1, 0);
    check_launch(m, 1'b0, 1'b1);
    finish_wait(6);

`ifndef MDSA_LOADER_PINGPONG_EN
    // Backpressure while the previous matrix waits on rdy
    fill_rand(m);
    fill_rand(m2);
    send(m, N, N - 1, 0);
    check_launch(m, 1'b0, 1'b1);
    s_valid = 1'b1; s_data = m2[0]; s_last = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("s_ready_backpressure", 32'(s_ready), 32'd0);
      @(negedge clk);
    end
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0; s_valid = 1'b0;
    chk("s_ready_after_rdy", 32'(s_ready), 32'd1);
    send(m2, N, N - 1, 0);
    check_launch(m2, 1'b0, 1'b1);
    finish_wait(1);
`endif

    // Early s_last on the 5th element discards the partial matrix
    fill_rand(m);
    send(m, 5, 4, 0);
    chk("frame_err_early", 32'(frame_err), 32'd1);
    chk("start_after_early", 32'(start), 32'd0);
    chk("busy_after_early", 32'(busy), 32'd0);
    @(negedge clk);
    chk("frame_err_one_cycle", 32'(frame_err), 32'd0);
    chk("start_still_lo", 32'(start), 32'd0);
    fill_rand(m);
    send(m, N, N - 1, 1);
    check_launch(m, 1'b0, 1'b1);
    finish_wait(2);

    // Missing s_last still launches with a frame_err pulse
    fill_rand(m);
    send(m, N, -1, 0);
    check_launch(m, 1'b1, 1'b1);
    finish_wait(1);

    // Reset during the 4th en cycle
    fill_rand(m);
    send(m, N, N - 1, 0);
    repeat (SC) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("pre_rst_data", 32'(data_in), 32'(m[i]));
      @(negedge clk);
    end
    chk("pre_rst_en", 32'(en), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_en", 32'(en), 32'd0);
    chk("async_rst_start", 32'(start), 32'd0);
    chk("async_rst_data", 32'(data_in), 32'd0);
    chk("async_rst_mat_cnt", 32'(mat_cnt), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    exp_mat = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("s_ready_after_midrst", 32'(s_ready), 32'd1);
    fill_rand(m);
    send(m, N, N - 1, 1);
    check_launch(m, 1'b0, 1'b1);
    finish_wait(0);

`ifdef MDSA_LOADER_PINGPONG_EN
    // Back-to-back matrices: the second fills during the first launch
    fill_rand(m);
    fill_rand(m2);
    send(m, N, N - 1, 0);
    fork
      check_launch(m, 1'b0, 1'b0);
      send(m2, N, N - 1, 0);
    join
    chk("s_ready_both_full", 32'(s_ready), 32'd0);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    check_launch(m2, 1'b0, 1'b1);
    finish_wait(1);
`endif

    // Randomized matrices, gaps and rdy level (rdy asserted early must be ignored until WAIT)
    for (int r = 0; r < 12; r++) begin
      logic rdy_early;
      int   hold;
      fill_rand(m);
      rdy_early = 1'($urandom_range(1, 0));
      hold      = rdy_early ? 0 : int'($urandom_range(3, 0));
      send(m, N, N - 1, 2);
      rdy = rdy_early;
      check_launch(m, 1'b0, 1'b1);
      finish_wait(hold);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mdsa_input_loader.md
Name: mdsa_input_loader

Overview:
Upstream feeder for MDSA_top.
- Accepts a valid/ready element stream and buffers one full ROWS x COLS matrix.
- Then drives the sorter's start/en/data_in sequence: a start pulse, followed by one element per cycle.
- Waits for the sorter's rdy before launching the next matrix.
- Sits between the system data source and MDSA_top, and replaces the testbench-driven start/en stimulus in integrated builds.

Parameters:
DATA_W, 8, element width in bits; equals MDSA_top data_in width
ROWS, 3, matrix rows
COLS, 3, matrix columns; N = ROWS*COLS elements per matrix
START_CYCLES, 4, number of cycles start is held high per launch (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
s_valid  in  1  upstream element valid
s_ready  out  1  loader can accept an element
s_data  in  DATA_W  upstream element
s_last  in  1  marks final element of a matrix
start  out  1  to MDSA_top start
en  out  1  to MDSA_top en; qualifies data_in
data_in  out  DATA_W  to MDSA_top data_in, one element per en cycle
rdy  in  1  from MDSA_top; high = sort complete, sorter free
frame_err  out  1  one-cycle pulse on s_last/count mismatch
busy  out  1  high in any state other than IDLE
mat_cnt  out  16  matrices launched since reset, wraps at 65535->0

Behaviour:
- Reset (asynchronous): all outputs 0, mat_cnt 0, wr_cnt/rd_cnt 0, state IDLE. Reset asserted mid-operation abandons the matrix; start and en drop immediately. s_ready returns high on the first clock after deassertion.
- Accept: an element is accepted when s_valid&&s_ready on a clock edge. It is written to buf[wr_cnt] in row-major arrival order, then wr_cnt increments.
- State IDLE: s_ready=1. First accept moves to FILL.
- State FILL: s_ready=1, accepting elements.
  - Accept with wr_cnt==N-1 and s_last=1: matrix complete; next state LAUNCH.
  - Accept with wr_cnt==N-1 and s_last=0: frame_err pulses. The matrix is still treated as complete; next state LAUNCH.
  - Accept with s_last=1 and wr_cnt<N-1: frame_err pulses. The partial matrix is discarded, wr_cnt=0, next state IDLE.
- State LAUNCH: s_ready=0, start=1 for exactly START_CYCLES cycles, en=0. mat_cnt increments on entry. Next state STREAM.
- State STREAM: en=1 and data_in=buf[rd_cnt] for exactly N consecutive cycles, rd_cnt 0..N-1. start=0. Next state WAIT_RDY.
- State WAIT_RDY: en=0, data_in held at 0. Move to IDLE on the first cycle rdy==1; rdy is sampled as a level, not an edge. No timeout.
- Latency: last element accepted at edge t gives:
  - start high in cycles t+1 .. t+START_CYCLES;
  - first en in cycle t+START_CYCLES+1;
  - last en in cycle t+START_CYCLES+N.
- Ordering guarantees:
  - data_in is 0 whenever en=0.
  - start and en are never high in the same cycle.
  - rdy is ignored outside WAIT_RDY.

Optional Feature:
MDSA_LOADER_PINGPONG_EN
- Defined: two buffer banks.
  - While one bank is in LAUNCH/STREAM/WAIT_RDY, the other bank fills; s_ready=1 until that bank holds N elements.
  - Leaving WAIT_RDY with the other bank full goes directly to LAUNCH, with no IDLE cycle.
  - Banks alternate strictly; frame_err rules apply per bank.
- Undefined: single bank. s_ready=0 in LAUNCH, STREAM and WAIT_RDY, exactly as described above.

Test Plan:
- Basic launch (N=9, START_CYCLES=4): send 9,8,...,1 with s_last on 1 → start high 4 cycles, then en 9 cycles with data_in 9,8,...,1 → mat_cnt=1; hold rdy=0 → busy stays 1; rdy=1 → IDLE.
- Backpressure: stream a second matrix while the first waits on rdy (macro off) → s_ready=0 and no element accepted until rdy=1; second matrix then streams intact.
- Early s_last: assert s_last on 5th element → frame_err pulses one cycle, no start; the following 9 good elements launch normally with correct data.
- Missing s_last: 9 elements with s_last=0 → frame_err pulse and launch still occurs with all 9 values.
- Reset mid-STREAM: assert rst at 4th en cycle → en/start drop asynchronously, mat_cnt=0, s_ready=1 after release; a fresh matrix launches correctly.
- Ping-pong (macro on): back-to-back 2 matrices with rdy pulsed after the first → second start begins the cycle after WAIT_RDY exits, with no IDLE gap; data order preserved per bank.
